// File: rtl/fifo_wr_arbiter_if.sv
// Write-port bundle between NUM_REQ requesters, the arbiter and the FIFO.
//   req / req_data : per-requester request and packed write word
//   fifo_full      : full flag from the downstream FIFO
//   gnt / owner    : one-hot grant and index of current/last grant holder
//   busy           : a grant is held
//   fifo_we / fifo_w_data : write strobe and word to the FIFO
// master = requester/FIFO side, slave = arbiter side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            gnt;
  logic [OW-1:0]                 owner;
  logic                          busy;
  logic                          fifo_full;
  logic                          fifo_we;
  logic [DATA_WIDTH-1:0]         fifo_w_data;

  modport master (
    output req, req_data, fifo_full,
    input  gnt, owner, busy, fifo_we, fifo_w_data
  );

  modport slave (
    input  req, req_data, fifo_full,
    output gnt, owner, busy, fifo_we, fifo_w_data
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ writers.
// A grant lasts up to MAX_BURST beats, ends early when the owner drops req,
// and is always followed by at least one IDLE cycle.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : fifo_wr_arbiter_if slave (req/req_data/fifo_full in,
//         gnt/owner/busy/fifo_we/fifo_w_data out)
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [OW-1:0]      owner_q, owner_d;
  logic [OW-1:0]      last_q, last_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [OW-1:0]      cand, win;
  logic               found;
  logic               xfer;

  // Round-robin pick: first requester scanning up from last_q+1, wrapping.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = OW'((int'(last_q) + k) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Beat transfer is purely combinational so the FIFO sees the write in the
  // same cycle the owner presents it.
  assign xfer = (state_q == BUSY) && bus.req[owner_q] && !bus.fifo_full;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    case (state_q)
      IDLE: begin
        if (found && !bus.fifo_full) begin
          state_d = BUSY;
          gnt_d   = NUM_REQ'(1) << win;
          owner_d = win;
          last_d  = win;
          beat_d  = '0;
        end
      end
      BUSY: begin
        // Owner dropping req releases even under back-pressure.
        if (!bus.req[owner_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (xfer) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == BW'(MAX_BURST - 1)) begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // last_q resets to NUM_REQ-1 so requester 0 has first priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= OW'(NUM_REQ - 1);
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.busy        = (state_q == BUSY);
  assign bus.fifo_we     = xfer;
  assign bus.fifo_w_data = (state_q == BUSY) ?
                           bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
endmodule
